// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
//
// Sequential AES key schedule for AES-128/192/256 (selected by NK). A start
// request loads the cipher key into a round-key table and then derives one
// 32-bit schedule word per clock until all 4*(NR+1) words exist. Any round
// key can then be fetched through a one-cycle registered read port.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        load key_in and expand (accepted only when idle)
//   key_in     in   32*NK    cipher key, word 0 in the MSBs
//   busy       out  1        expansion in progress
//   done       out  1        one-cycle pulse when the schedule is complete
//   key_valid  out  1        table holds a full schedule for the last key
//   rd_en      in   1        round-key read request
//   rd_round   in   4        round index 0..NR
//   rd_key     out  128      round key w[4r]..w[4r+3], w[4r] in the MSBs
//   rd_valid   out  1        rd_key carries the result of last cycle's read
//
// Also contains sbox: the combinational AES forward S-box, one byte in,
// one byte out.
// ---------------------------------------------------------------------------

module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Byte n of the table lives at bits [8n : 8n+7] (ascending range, so the
  // first literal byte is entry 0).
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_base;

  assign bit_base = {a_i, 3'b000};
  assign y_o      = SBOX_TABLE[bit_base +: 8];

endmodule


module aes_key_expander #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  input  logic              rd_en,
  input  logic [3:0]        rd_round,
  output logic [127:0]      rd_key,
  output logic              rd_valid
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);
  localparam int IW    = 6;   // holds 0..TOTAL (max 60)
  localparam int PW    = 3;   // phase 0..NK-1 (max 7)

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_key_expander: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            key_valid_q, key_valid_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [7:0]      rcon_q, rcon_d;

  // Round-key table (not reset) and a sliding window of the last NK words.
  // The window gives w[i-NK] and w[i-1] without extra table read ports:
  // win_q[0] = w[i-NK], win_q[NK-1] = w[i-1].
  logic [31:0]     tbl_q [TOTAL];
  logic [31:0]     win_q [NK];

  logic [127:0]    rd_key_q;
  logic            rd_valid_q;

  // -------------------------------------------------------------------------
  // Schedule datapath
  // -------------------------------------------------------------------------
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic        use_rot;
  logic        use_sub;
  logic [31:0] sbox_in;
  logic [31:0] sub_w;
  logic [31:0] t_w;
  logic [31:0] new_w;
  logic [7:0]  rcon_xtime;
  logic        last_word;
  logic        accept;
  logic        expand_we;

  assign prev_w  = win_q[NK-1];
  assign old_w   = win_q[0];

  // Phase 0 is the i mod NK == 0 step; for AES-256 phase 4 also needs
  // SubWord, but without rotation or rcon.
  assign use_rot = (phase_q == '0);
  assign use_sub = use_rot || ((NK == 8) && (phase_q == PW'(4)));

  // The four S-boxes are shared between both SubWord flavours; only the
  // input byte order changes.
  assign sbox_in = use_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .a_i (sbox_in[8*gi +: 8]),
        .y_o (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    t_w = prev_w;
    if (use_rot) begin
      t_w = sub_w ^ {rcon_q, 24'h000000};
    end else if (use_sub) begin
      t_w = sub_w;
    end
  end

  assign new_w      = old_w ^ t_w;
  assign rcon_xtime = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign last_word  = (idx_q == IW'(TOTAL - 1));
  assign accept     = (state_q == IDLE) && start;
  assign expand_we  = (state_q == EXPAND);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    rcon_d      = rcon_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = EXPAND;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
          idx_d       = IW'(NK);
          phase_d     = '0;
          rcon_d      = 8'h01;
        end
      end

      EXPAND: begin
        idx_d   = idx_q + IW'(1);
        phase_d = (phase_q == PW'(NK - 1)) ? '0 : phase_q + PW'(1);
        if (use_rot) begin
          rcon_d = rcon_xtime;
        end
        if (last_word) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      idx_q       <= '0;
      phase_q     <= '0;
      rcon_q      <= 8'h01;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      rcon_q      <= rcon_d;
    end
  end

  // -------------------------------------------------------------------------
  // Table and window writes. Writes only happen in EXPAND or on acceptance,
  // both of which are gated by the reset state register, so no reset here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++) begin
        win_q[k] <= key_in[32*(NK-1-k) +: 32];
        tbl_q[k] <= key_in[32*(NK-1-k) +: 32];
      end
    end else if (expand_we) begin
      for (int k = 0; k < NK - 1; k++) begin
        win_q[k] <= win_q[k+1];
      end
      win_q[NK-1]  <= new_w;
      tbl_q[idx_q] <= new_w;
    end
  end

  // -------------------------------------------------------------------------
  // Read port. The index is clamped before addressing the table so an
  // out-of-range round never indexes past the end; the data is zeroed
  // instead. A read of a word being written this edge sees the old value.
  // -------------------------------------------------------------------------
  logic         rd_in_range;
  logic [3:0]   rd_sel;
  logic [31:0]  rd_word [4];
  logic [127:0] rd_data;

  assign rd_in_range = (rd_round <= 4'(NR));
  assign rd_sel      = rd_in_range ? rd_round : 4'd0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_word
      localparam logic [1:0] OFF = 2'(gi);
      assign rd_word[gi] = tbl_q[{rd_sel, OFF}];
    end
  endgenerate

  assign rd_data = rd_in_range ? {rd_word[0], rd_word[1], rd_word[2], rd_word[3]}
                               : 128'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_key_q <= rd_data;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign rd_key    = rd_key_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
//
// Directed bench for aes_key_expander with one instance per key size
// (NK = 4, 6, 8). Expected round keys are the FIPS-197 appendix A values.
// ---------------------------------------------------------------------------

module tb_aes_key_expander;

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KALT  = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk;
  logic rst_n;

  logic         start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         busy4, busy6, busy8;
  logic         done4, done6, done8;
  logic         kv4, kv6, kv8;
  logic         rd_en4, rd_en6, rd_en8;
  logic [3:0]   rd_round4, rd_round6, rd_round8;
  logic [127:0] rd_key4, rd_key6, rd_key8;
  logic         rd_valid4, rd_valid6, rd_valid8;

  int tests;
  int fails;

  aes_key_expander #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .key_valid(kv4),
    .rd_en(rd_en4), .rd_round(rd_round4), .rd_key(rd_key4), .rd_valid(rd_valid4)
  );

  aes_key_expander #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .key_valid(kv6),
    .rd_en(rd_en6), .rd_round(rd_round6), .rd_key(rd_key6), .rd_valid(rd_valid6)
  );

  aes_key_expander #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .key_valid(kv8),
    .rd_en(rd_en8), .rd_round(rd_round8), .rd_key(rd_key8), .rd_valid(rd_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------
  // Pulse start for one edge; returns #1 after the acceptance edge.
  task automatic start_key(input int nk, input logic [255:0] k);
    @(negedge clk);
    case (nk)
      4:       begin start4 = 1'b1; key4 = k[127:0]; end
      6:       begin start6 = 1'b1; key6 = k[191:0]; end
      default: begin start8 = 1'b1; key8 = k;        end
    endcase
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
  endtask

  // Counts edges until done is seen high (sampled #1 after each edge);
  // -1 if it never comes within the budget.
  task automatic wait_done(input int nk, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      case (nk)
        4:       seen = done4;
        6:       seen = done6;
        default: seen = done8;
      endcase
    end
    if (!seen) cyc = -1;
  endtask

  task automatic do_read(input int nk, input logic [3:0] r,
                         output logic [127:0] k, output logic v);
    @(negedge clk);
    case (nk)
      4:       begin rd_en4 = 1'b1; rd_round4 = r; end
      6:       begin rd_en6 = 1'b1; rd_round6 = r; end
      default: begin rd_en8 = 1'b1; rd_round8 = r; end
    endcase
    @(posedge clk);
    #1;
    case (nk)
      4:       begin k = rd_key4; v = rd_valid4; end
      6:       begin k = rd_key6; v = rd_valid6; end
      default: begin k = rd_key8; v = rd_valid8; end
    endcase
    rd_en4 = 1'b0;
    rd_en6 = 1'b0;
    rd_en8 = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy4, done4, kv4, rd_valid4} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags4: got %b expected 0000", {busy4, done4, kv4, rd_valid4});
    end
    tests++;
    if (rd_key4 !== 128'h0) begin
      fails++;
      $display("FAIL reset_rd_key4: got %h expected 0", rd_key4);
    end
    tests++;
    if ({busy6, kv6, busy8, kv8} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags68: got %b expected 0000", {busy6, kv6, busy8, kv8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_aes128();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(4, {128'h0, K128});
    tests++;
    if ({busy4, kv4} !== 2'b10) begin
      fails++;
      $display("FAIL aes128_accept: got busy/kv %b expected 10", {busy4, kv4});
    end
    wait_done(4, cyc);
    tests++;
    if (cyc !== 40) begin
      fails++;
      $display("FAIL aes128_latency: got %0d expected 40", cyc);
    end
    tests++;
    if ({busy4, kv4} !== 2'b01) begin
      fails++;
      $display("FAIL aes128_complete: got busy/kv %b expected 01", {busy4, kv4});
    end
    @(posedge clk);
    #1;
    tests++;
    if (done4 !== 1'b0) begin
      fails++;
      $display("FAIL aes128_done_pulse: got %b expected 0", done4);
    end
    do_read(4, 4'd0, k, v);
    tests++;
    if (k !== K128 || v !== 1'b1) begin
      fails++;
      $display("FAIL aes128_round0: got %h/%b expected %h/1", k, v, K128);
    end
    do_read(4, 4'd1, k, v);
    tests++;
    if (k !== R128_1) begin
      fails++;
      $display("FAIL aes128_round1: got %h expected %h", k, R128_1);
    end
    do_read(4, 4'd2, k, v);
    tests++;
    if (k !== R128_2) begin
      fails++;
      $display("FAIL aes128_round2: got %h expected %h", k, R128_2);
    end
    do_read(4, 4'd10, k, v);
    tests++;
    if (k !== R128_10) begin
      fails++;
      $display("FAIL aes128_round10: got %h expected %h", k, R128_10);
    end
    $display("[TB] aes128 expansion %0d cycles, round10 %h", cyc, k);
  endtask

  task automatic test_aes192();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(6, {64'h0, K192});
    wait_done(6, cyc);
    tests++;
    if (cyc !== 46) begin
      fails++;
      $display("FAIL aes192_latency: got %0d expected 46", cyc);
    end
    do_read(6, 4'd1, k, v);
    tests++;
    if (k !== R192_1) begin
      fails++;
      $display("FAIL aes192_round1: got %h expected %h", k, R192_1);
    end
    do_read(6, 4'd12, k, v);
    tests++;
    if (k !== R192_12 || v !== 1'b1) begin
      fails++;
      $display("FAIL aes192_round12: got %h/%b expected %h/1", k, v, R192_12);
    end
    $display("[TB] aes192 expansion %0d cycles, round12 %h", cyc, k);
  endtask

  task automatic test_aes256();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(8, K256);
    wait_done(8, cyc);
    tests++;
    if (cyc !== 52) begin
      fails++;
      $display("FAIL aes256_latency: got %0d expected 52", cyc);
    end
    do_read(8, 4'd0, k, v);
    tests++;
    if (k !== K256[255:128]) begin
      fails++;
      $display("FAIL aes256_round0: got %h expected %h", k, K256[255:128]);
    end
    do_read(8, 4'd1, k, v);
    tests++;
    if (k !== R256_1) begin
      fails++;
      $display("FAIL aes256_round1: got %h expected %h", k, R256_1);
    end
    do_read(8, 4'd2, k, v);
    tests++;
    if (k !== R256_2) begin
      fails++;
      $display("FAIL aes256_round2: got %h expected %h", k, R256_2);
    end
    do_read(8, 4'd14, k, v);
    tests++;
    if (k !== R256_14) begin
      fails++;
      $display("FAIL aes256_round14: got %h expected %h", k, R256_14);
    end
    $display("[TB] aes256 expansion %0d cycles, round14 %h", cyc, k);
  endtask

  task automatic test_read_boundaries();
    logic [127:0] k;
    logic v;
    do_read(4, 4'd15, k, v);
    tests++;
    if (k !== 128'h0 || v !== 1'b1) begin
      fails++;
      $display("FAIL read_round15: got %h/%b expected 0/1", k, v);
    end
    do_read(4, 4'd11, k, v);
    tests++;
    if (k !== 128'h0 || v !== 1'b1) begin
      fails++;
      $display("FAIL read_round11_nk4: got %h/%b expected 0/1", k, v);
    end
    do_read(6, 4'd13, k, v);
    tests++;
    if (k !== 128'h0 || v !== 1'b1) begin
      fails++;
      $display("FAIL read_round13_nk6: got %h/%b expected 0/1", k, v);
    end
    @(posedge clk);
    #1;
    tests++;
    if (rd_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL read_valid_drop: got %b expected 0", rd_valid4);
    end
    $display("[TB] read boundaries checked");
  endtask

  task automatic test_start_during_busy();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(4, {128'h0, K128});
    repeat (19) @(posedge clk);
    @(negedge clk);
    start4 = 1'b1;
    key4   = KALT;
    @(posedge clk);          // edge 20 of the expansion
    #1;
    start4 = 1'b0;
    tests++;
    if ({busy4, kv4} !== 2'b10) begin
      fails++;
      $display("FAIL busy_start_state: got busy/kv %b expected 10", {busy4, kv4});
    end
    wait_done(4, cyc);
    tests++;
    if (cyc !== 20) begin
      fails++;
      $display("FAIL busy_start_remaining: got %0d expected 20", cyc);
    end
    do_read(4, 4'd10, k, v);
    tests++;
    if (k !== R128_10) begin
      fails++;
      $display("FAIL busy_start_round10: got %h expected %h", k, R128_10);
    end
    $display("[TB] start during busy ignored, round10 %h", k);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(4, {128'h0, KALT});
    wait_done(4, cyc);
    // done is high now; request the next key in the same cycle.
    start4 = 1'b1;
    key4   = K128;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    tests++;
    if ({busy4, done4, kv4} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_restart: got busy/done/kv %b expected 100", {busy4, done4, kv4});
    end
    wait_done(4, cyc);
    tests++;
    if (cyc !== 40) begin
      fails++;
      $display("FAIL b2b_latency: got %0d expected 40", cyc);
    end
    do_read(4, 4'd10, k, v);
    tests++;
    if (k !== R128_10) begin
      fails++;
      $display("FAIL b2b_round10: got %h expected %h", k, R128_10);
    end
    $display("[TB] back-to-back restart, round10 %h", k);
  endtask

  task automatic test_reset_mid_expansion();
    int cyc;
    logic [127:0] k;
    logic v;
    start_key(4, {128'h0, K128});
    rd_en4    = 1'b1;
    rd_round4 = 4'd1;
    repeat (25) @(posedge clk);
    #1;
    tests++;
    if ({busy4, rd_valid4} !== 2'b11) begin
      fails++;
      $display("FAIL midrst_pre: got busy/rd_valid %b expected 11", {busy4, rd_valid4});
    end
    #1;
    rst_n = 1'b0;
    #1;                      // still well before the next clock edge
    tests++;
    if ({busy4, done4, kv4, rd_valid4} !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_flags: got %b expected 0000", {busy4, done4, kv4, rd_valid4});
    end
    tests++;
    if (rd_key4 !== 128'h0) begin
      fails++;
      $display("FAIL midrst_rd_key: got %h expected 0", rd_key4);
    end
    rd_en4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (kv4 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_kv_after: got %b expected 0", kv4);
    end
    start_key(4, {128'h0, K128});
    wait_done(4, cyc);
    tests++;
    if (cyc !== 40) begin
      fails++;
      $display("FAIL midrst_latency: got %0d expected 40", cyc);
    end
    do_read(4, 4'd1, k, v);
    tests++;
    if (k !== R128_1) begin
      fails++;
      $display("FAIL midrst_round1: got %h expected %h", k, R128_1);
    end
    do_read(4, 4'd10, k, v);
    tests++;
    if (k !== R128_10) begin
      fails++;
      $display("FAIL midrst_round10: got %h expected %h", k, R128_10);
    end
    $display("[TB] reset mid-expansion then re-expand, round10 %h", k);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    start4    = 1'b0;
    start6    = 1'b0;
    start8    = 1'b0;
    key4      = '0;
    key6      = '0;
    key8      = '0;
    rd_en4    = 1'b0;
    rd_en6    = 1'b0;
    rd_en8    = 1'b0;
    rd_round4 = '0;
    rd_round6 = '0;
    rd_round8 = '0;
    rst_n     = 1'b1;

    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_read_boundaries();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_expansion();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
